frame_proc_fsm: RTL and testbench

FRAME_PROC_FSM -- requirements
Module: frame_proc_fsm

---
 rtl/frame_proc_fsm.sv | 158 +++++++++++++++
 tb/tb_frame_proc_fsm.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/frame_proc_fsm.sv
// ---------------------------------------------------------------------------
// frame_proc_fsm
//
// Frame sequencing state machine. A frame consists of four SOF header words,
// a payload that lasts as long as VALID stays high, one CRC cycle, four EOF
// trailer words and an eight-cycle inter-frame gap. Header and trailer words
// are addressed through an external 3-bit ROM address counter that this block
// advances (inc_rom) or clears (rst_rom).
//
// Ports
//   clk        in   1  clock, all state changes on the rising edge
//   rst        in   1  asynchronous active-high reset
//   valid      in   1  upstream payload available
//   rom_addr   in   3  current external ROM address
//   clr_crc    out  1  clear downstream CRC accumulator
//   crc_dv     out  1  current data word enters the CRC
//   inc_rom    out  1  advance external ROM address counter
//   rst_rom    out  1  clear external ROM address counter
//   tx_ack     out  1  payload word accepted (upstream pops one word)
//   frm_state  out  4  binary state code, for debug
// ---------------------------------------------------------------------------
module frame_proc_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [2:0] rom_addr,
    output logic       clr_crc,
    output logic       crc_dv,
    output logic       inc_rom,
    output logic       rst_rom,
    output logic       tx_ack,
    output logic [3:0] frm_state
);

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_SOF  = 4'd1;
    localparam logic [3:0] ST_DATA = 4'd2;
    localparam logic [3:0] ST_CRC  = 4'd3;
    localparam logic [3:0] ST_EOF  = 4'd4;
    localparam logic [3:0] ST_IFG  = 4'd5;

    // Last ROM word of the header and of the trailer.
    localparam logic [2:0] SOF_LAST = 3'd3;
    localparam logic [2:0] EOF_LAST = 3'd7;
    localparam logic [2:0] GAP_LAST = 3'd7;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [2:0] gap_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Inter-frame gap counter: runs only while in IFG, so it is zero on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= 3'd0;
        end else if (state == ST_IFG) begin
            gap_cnt <= gap_cnt + 3'd1;
        end else begin
            gap_cnt <= 3'd0;
        end
    end

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (valid) begin
                    state_nxt = ST_SOF;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SOF: begin
                // The counter reaches 4 on the same edge we leave.
                if (rom_addr == SOF_LAST) begin
                    state_nxt = ST_DATA;
                end else begin
                    state_nxt = ST_SOF;
                end
            end
            ST_DATA: begin
                if (valid) begin
                    state_nxt = ST_DATA;
                end else begin
                    state_nxt = ST_CRC;
                end
            end
            ST_CRC: begin
                state_nxt = ST_EOF;
            end
            ST_EOF: begin
                if (rom_addr == EOF_LAST) begin
                    state_nxt = ST_IFG;
                end else begin
                    state_nxt = ST_EOF;
                end
            end
            ST_IFG: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_IFG;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode. rst_rom/clr_crc depend on the state register alone so
    // they cannot glitch with valid; only the payload strobes follow valid.
    always_comb begin
        clr_crc = 1'b0;
        crc_dv  = 1'b0;
        inc_rom = 1'b0;
        rst_rom = 1'b0;
        tx_ack  = 1'b0;
        case (state)
            ST_IDLE: begin
                rst_rom = 1'b1;
                clr_crc = 1'b1;
            end
            ST_SOF: begin
                inc_rom = 1'b1;
            end
            ST_DATA: begin
                tx_ack = valid;
                crc_dv = valid;
            end
            ST_CRC: begin
                inc_rom = 1'b0;
            end
            ST_EOF: begin
                inc_rom = 1'b1;
            end
            ST_IFG: begin
                rst_rom = 1'b1;
                clr_crc = 1'b1;
            end
            default: begin
                rst_rom = 1'b0;
            end
        endcase
    end

    assign frm_state = state;

endmodule

// File: tb/tb_frame_proc_fsm.sv
module tb_frame_proc_fsm;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [2:0] rom_addr;
    logic       clr_crc;
    logic       crc_dv;
    logic       inc_rom;
    logic       rst_rom;
    logic       tx_ack;
    logic [3:0] frm_state;

    frame_proc_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .rom_addr  (rom_addr),
        .clr_crc   (clr_crc),
        .crc_dv    (crc_dv),
        .inc_rom   (inc_rom),
        .rst_rom   (rst_rom),
        .tx_ack    (tx_ack),
        .frm_state (frm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External ROM address counter; rst_rom acts as an asynchronous clear.
    logic [2:0] rom_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_cnt <= 3'd0;
        end else if (rst_rom) begin
            rom_cnt <= 3'd0;
        end else if (inc_rom) begin
            rom_cnt <= rom_cnt + 3'd1;
        end
    end
    assign rom_addr = rst_rom ? 3'd0 : rom_cnt;

    int pass_cnt;
    int total_cnt;

    // Reference model: frame phase plus cycles already spent in that phase.
    // Phase codes: 0 idle, 1 sof, 2 data, 3 crc, 4 eof, 5 ifg.
    int m_ph;
    int m_k;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        logic [3:0] e_addr;
        logic       gap_or_idle;
        logic       counting;
        gap_or_idle = (m_ph == 0) || (m_ph == 5);
        counting    = (m_ph == 1) || (m_ph == 4);
        case (m_ph)
            1:       e_addr = 4'(m_k);
            2, 3:    e_addr = 4'd4;
            4:       e_addr = 4'(4 + m_k);
            default: e_addr = 4'd0;
        endcase
        chk("frm_state", frm_state, 4'(m_ph));
        chk("rst_rom", {3'd0, rst_rom}, {3'd0, gap_or_idle});
        chk("clr_crc", {3'd0, clr_crc}, {3'd0, gap_or_idle});
        chk("inc_rom", {3'd0, inc_rom}, {3'd0, counting});
        chk("tx_ack", {3'd0, tx_ack}, {3'd0, (m_ph == 2) && valid});
        chk("crc_dv", {3'd0, crc_dv}, {3'd0, (m_ph == 2) && valid});
        chk("rom_addr", {1'b0, rom_addr}, e_addr);
    endtask

    task automatic model_step(input logic v);
        case (m_ph)
            0: if (v) begin m_ph = 1; m_k = 0; end
            1: begin m_k++; if (m_k == 4) begin m_ph = 2; m_k = 0; end end
            2: if (!v) m_ph = 3;
            3: begin m_ph = 4; m_k = 0; end
            4: begin m_k++; if (m_k == 4) begin m_ph = 5; m_k = 0; end end
            5: begin m_k++; if (m_k == 8) begin m_ph = 0; m_k = 0; end end
            default: begin m_ph = 0; m_k = 0; end
        endcase
    endtask

    // One clock cycle with the given valid level; entered and left at posedge+1.
    task automatic cyc(input logic v);
        valid = v;
        #2;
        check_all();
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    // Reset pulse asserted mid-cycle, held for n edges with valid driven to v.
    task automatic reset_pulse(input int n, input logic v);
        valid = v;
        #2;
        rst = 1'b1;
        #1;
        m_ph = 0;
        m_k  = 0;
        check_all();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rst = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        m_ph      = 0;
        m_k       = 0;
        rst       = 1'b1;
        valid     = 1'b0;

        // Power-on reset, valid low, five cycles.
        #1;
        check_all();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rst = 1'b0;

        // Long frame: valid held 810 cycles, then drained through the IFG.
        for (int i = 0; i < 810; i++) cyc(1'b1);
        for (int i = 0; i < 25; i++) cyc(1'b0);

        // Single-cycle valid pulse: zero-length payload.
        cyc(1'b1);
        for (int i = 0; i < 25; i++) cyc(1'b0);

        // Valid kept high through CRC, EOF and IFG: restart straight from IDLE.
        for (int i = 0; i < 12; i++) cyc(1'b1);
        cyc(1'b0);
        for (int i = 0; i < 30; i++) cyc(1'b1);
        for (int i = 0; i < 25; i++) cyc(1'b0);

        // Reset during DATA with valid high; valid still high after release.
        for (int i = 0; i < 10; i++) cyc(1'b1);
        reset_pulse(2, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1);
        for (int i = 0; i < 25; i++) cyc(1'b0);

        // Randomised valid with bursts of random length.
        for (int b = 0; b < 40; b++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) cyc(lvl);
        end

        // Reset at a random point of a random frame.
        for (int i = 0; i < int'($urandom_range(2, 20)); i++) cyc(1'b1);
        reset_pulse(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 40; i++) cyc(1'($urandom_range(0, 1)));
        for (int i = 0; i < 25; i++) cyc(1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
